// File: rtl/conv_sched_if.sv
// conv_sched_if: handshake and MAC bus between the convolution scheduler and its environment.
// The master modport is the scheduler side; the slave modport is the MAC/consumer side.
interface conv_sched_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  index_in;
  logic [7:0]  index_w;
  logic        mac_en;
  logic [15:0] mac_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_pos;

  modport master (
    input  start, mac_prod, out_ready,
    output busy, done, index_in, index_w, mac_en, out_valid, out_data, out_pos
  );

  modport slave (
    output start, mac_prod, out_ready,
    input  busy, done, index_in, index_w, mac_en, out_valid, out_data, out_pos
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: walks a 1-D row convolution, one filter tap per cycle, and hands each
// accumulated result to a ready/valid consumer.
// Optional macro CONV_SCHED_SAT_EN: saturate out_data to 16'hFFFF when the sum overflows
// 16 bits. Without it out_data is the low 16 bits of the sum (wrap-around).
module conv_sched #(
  parameter int unsigned ROW_LENGTH  = 28,
  parameter int unsigned FILTER_SIZE = 5
) (
  input logic        clk,
  input logic        rst_n,
  conv_sched_if.master bus
);

  localparam int unsigned LastPos = ROW_LENGTH - FILTER_SIZE - 1;
  localparam int unsigned LastTap = FILTER_SIZE - 1;

  typedef enum logic [1:0] {StIdle, StRun, StEmit, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [7:0]  r_p, w_p_next;
  logic [7:0]  r_k, w_k_next;
  logic [19:0] r_acc, w_acc_next;
  logic [15:0] r_out_data, w_out_data_next;
  logic [19:0] w_sum;
  logic [15:0] w_result;

  // Running sum including the product for the current tap.
  always_comb begin
    w_sum = r_acc + {4'd0, bus.mac_prod};
`ifdef CONV_SCHED_SAT_EN
    w_result = (w_sum > 20'h0FFFF) ? 16'hFFFF : w_sum[15:0];
`else
    w_result = w_sum[15:0];
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_p        <= 8'd0;
      r_k        <= 8'd0;
      r_acc      <= 20'd0;
      r_out_data <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_p        <= w_p_next;
      r_k        <= w_k_next;
      r_acc      <= w_acc_next;
      r_out_data <= w_out_data_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_next    = r_state;
    w_p_next        = r_p;
    w_k_next        = r_k;
    w_acc_next      = r_acc;
    w_out_data_next = r_out_data;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_p_next     = 8'd0;
          w_k_next     = 8'd0;
          w_acc_next   = 20'd0;
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_acc_next = w_sum;
        w_k_next   = r_k + 8'd1;
        if (r_k == 8'(LastTap)) begin
          w_out_data_next = w_result;
          w_state_next    = StEmit;
        end
      end
      StEmit: begin
        // out_valid is implied by this state, so ready alone completes the handshake.
        if (bus.out_ready) begin
          if (r_p == 8'(LastPos)) begin
            w_state_next = StDone;
          end else begin
            w_p_next     = r_p + 8'd1;
            w_k_next     = 8'd0;
            w_acc_next   = 20'd0;
            w_state_next = StRun;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; MAC indices are forced to zero outside RUN.
  always_comb begin
    bus.mac_en    = (r_state == StRun);
    bus.index_in  = (r_state == StRun) ? (r_p + r_k) : 8'd0;
    bus.index_w   = (r_state == StRun) ? r_k : 8'd0;
    bus.out_valid = (r_state == StEmit);
    bus.done      = (r_state == StDone);
    bus.busy      = (r_state != StIdle);
    bus.out_data  = r_out_data;
    bus.out_pos   = r_p;
  end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: table of row-level scenarios, each driven through a cycle-level model of the
// RUN/EMIT sequence with a queue of expected outputs.
module tb_conv_sched;

  localparam int RowLength  = 28;
  localparam int FilterSize = 5;
  localparam int NumOut     = RowLength - FilterSize;
  localparam int RowCycles  = NumOut * (FilterSize + 1) + 1;

`ifdef CONV_SCHED_SAT_EN
  localparam logic [15:0] ExpAllOnes = 16'hFFFF;
  localparam logic [15:0] ExpOver    = 16'hFFFF;
`else
  localparam logic [15:0] ExpAllOnes = 16'hFFFB;
  localparam logic [15:0] ExpOver    = 16'h0004;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int          mode;
  logic [15:0] cval;

  always #5 clk = ~clk;

  conv_sched_if bus ();

  // MAC model: constant product, or index_in + index_w.
  assign bus.mac_prod = (mode != 0) ? ({8'd0, bus.index_in} + {8'd0, bus.index_w}) : cval;

  conv_sched #(
    .ROW_LENGTH (RowLength),
    .FILTER_SIZE(FilterSize)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          pos;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          mode;
    logic [15:0] cval;
    int          stall_p;
    int          stall_len;
    int          pulses;
    int          abort_p;
    logic [15:0] base;
    logic [15:0] step;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " mac_en"}, 32'(bus.mac_en), 32'd0);
    check({tag, " index_in"}, 32'(bus.index_in), 32'd0);
    check({tag, " index_w"}, 32'(bus.index_w), 32'd0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, " out_pos"}, 32'(bus.out_pos), 32'd0);
  endtask

  task automatic run_row(input vec_t v);
    int c;
    int run_k;
    int stall_cnt;
    bit expect_done;
    bit finished;
    exp_t e;
    mode = v.mode;
    cval = v.cval;
    sb.delete();
    for (int p = 0; p < NumOut; p++) begin
      e.pos  = p;
      e.data = v.base + v.step * 16'(p);
      sb.push_back(e);
    end
    c = 0;
    run_k = 0;
    stall_cnt = 0;
    expect_done = 1'b0;
    finished = 1'b0;
    out_ready_set(1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    while (!finished && c < 400) begin
      @(negedge clk);
      c++;
      if (v.abort_p >= 0 && sb.size() > 0 && sb[0].pos == v.abort_p && run_k == 2) begin
        #2 rst_n = 1'b0;
        bus.start = 1'b0;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        check_zero_outputs("abort hold");
        rst_n = 1'b1;
        sb.delete();
        return;
      end
      if (expect_done) begin
        check("done pulse", 32'(bus.done), 32'd1);
        check("busy at done", 32'(bus.busy), 32'd1);
        check("done cycle", 32'(c), 32'(RowCycles + v.stall_len));
        finished = 1'b1;
      end else begin
        check("busy", 32'(bus.busy), 32'd1);
        check("no early done", 32'(bus.done), 32'd0);
        if (run_k < FilterSize) begin
          check("run mac_en", 32'(bus.mac_en), 32'd1);
          check("run out_valid", 32'(bus.out_valid), 32'd0);
          check("index_w", 32'(bus.index_w), 32'(run_k));
          check("index_in", 32'(bus.index_in), 32'(sb[0].pos + run_k));
          run_k++;
        end else begin
          check("emit out_valid", 32'(bus.out_valid), 32'd1);
          check("emit mac_en", 32'(bus.mac_en), 32'd0);
          check("emit index_in", 32'(bus.index_in), 32'd0);
          check("emit index_w", 32'(bus.index_w), 32'd0);
          check("out_data", 32'(bus.out_data), 32'(sb[0].data));
          check("out_pos", 32'(bus.out_pos), 32'(sb[0].pos));
          if (sb[0].pos == v.stall_p && stall_cnt < v.stall_len) begin
            out_ready_set(1'b0);
            stall_cnt++;
          end else begin
            out_ready_set(1'b1);
            void'(sb.pop_front());
            run_k = 0;
            if (sb.size() == 0) expect_done = 1'b1;
          end
        end
      end
      bus.start = (v.pulses != 0 && (c == 3 || c == 60 || c == 100)) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    if (!finished) begin
      n_checks++;
      n_errors++;
      $display("FAIL row timeout: got %0d cycles, expected done by %0d", c, RowCycles);
    end
    @(negedge clk);
    check("post done", 32'(bus.done), 32'd0);
    check("post busy", 32'(bus.busy), 32'd0);
    check("post out_valid", 32'(bus.out_valid), 32'd0);
    check("post mac_en", 32'(bus.mac_en), 32'd0);
  endtask

  task automatic out_ready_set(input logic val);
    bus.out_ready = val;
  endtask

  initial begin
    //         mode cval       stall_p len pulses abort base        step
    vecs[0] = '{0, 16'd3,     -1,     0,  0,     -1,   16'd15,     16'd0};
    vecs[1] = '{1, 16'd0,      4,     10, 0,     -1,   16'd20,     16'd5};
    vecs[2] = '{0, 16'hFFFF,  -1,     0,  0,     -1,   ExpAllOnes, 16'd0};
    vecs[3] = '{0, 16'd13108, -1,     0,  0,     -1,   ExpOver,    16'd0};
    vecs[4] = '{0, 16'd13107, -1,     0,  0,     -1,   16'hFFFF,   16'd0};
    vecs[5] = '{1, 16'd0,     -1,     0,  0,     10,   16'd20,     16'd5};
    vecs[6] = '{1, 16'd0,     -1,     0,  1,     -1,   16'd20,     16'd5};
    vecs[7] = '{0, 16'd0,     -1,     0,  0,     -1,   16'd0,      16'd0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    mode = 0;
    cval = 16'd0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_row(vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
